// File: rtl/timer_scheduler.sv
// timer_scheduler: lets NUM_CLIENTS requesters share one Timer for one-shot delays.
// A round-robin arbiter grants one client at a time, loads its delay into the Timer,
// waits for timer_interrupt and returns a one-cycle done pulse to that client.
//
// Ports:
//   clk              system clock
//   rst              asynchronous active-low reset
//   req              per-client request level
//   delay            per-client delay, client i at [i*DELAY_WIDTH +: DELAY_WIDTH]
//   ack              one-hot pulse: request accepted, delay latched
//   done             one-hot pulse: granted delay expired
//   busy             high from the grant cycle through the done cycle
//   owner            index of the current or last granted client
//   timer_write      Timer write strobe
//   timer_data       Timer data_in (latched delay)
//   timer_interrupt  Timer expiry level
module timer_scheduler #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned DELAY_WIDTH = 32,
  parameter int unsigned IDX_WIDTH   = $clog2(NUM_CLIENTS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CLIENTS-1:0]             req,
  input  logic [NUM_CLIENTS*DELAY_WIDTH-1:0] delay,
  output logic [NUM_CLIENTS-1:0]             ack,
  output logic [NUM_CLIENTS-1:0]             done,
  output logic                               busy,
  output logic [IDX_WIDTH-1:0]               owner,
  output logic                               timer_write,
  output logic [DELAY_WIDTH-1:0]             timer_data,
  input  logic                               timer_interrupt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [IDX_WIDTH-1:0]    r_last;
  logic [IDX_WIDTH-1:0]    r_owner;
  logic [NUM_CLIENTS-1:0]  r_ack;
  logic [NUM_CLIENTS-1:0]  r_done;
  logic                    r_busy;
  logic                    r_write;
  logic [DELAY_WIDTH-1:0]  r_data;

  logic [IDX_WIDTH-1:0]    w_last_nxt;
  logic [IDX_WIDTH-1:0]    w_owner_nxt;
  logic [NUM_CLIENTS-1:0]  w_ack_nxt;
  logic [NUM_CLIENTS-1:0]  w_done_nxt;
  logic                    w_busy_nxt;
  logic                    w_write_nxt;
  logic [DELAY_WIDTH-1:0]  w_data_nxt;

  logic                    w_found;
  logic [IDX_WIDTH-1:0]    w_winner;
  int unsigned             w_scan;
  logic [DELAY_WIDTH-1:0]  w_delay_arr [NUM_CLIENTS];

  // Unpack the flat delay bus into one entry per client.
  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
    assign w_delay_arr[g] = delay[g*DELAY_WIDTH +: DELAY_WIDTH];
  end

  // Round-robin search starting at last+1, wrapping modulo NUM_CLIENTS.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_scan   = 0;
    for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
      w_scan = 32'(r_last) + k;
      if (w_scan >= NUM_CLIENTS) begin
        w_scan = w_scan - NUM_CLIENTS;
      end
      if (!w_found && req[IDX_WIDTH'(w_scan)]) begin
        w_found  = 1'b1;
        w_winner = IDX_WIDTH'(w_scan);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = '0;
    w_done_nxt  = '0;
    w_write_nxt = 1'b0;
    w_owner_nxt = r_owner;
    w_data_nxt  = r_data;
    w_last_nxt  = r_last;
    w_busy_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_LOAD;
          w_ack_nxt   = NUM_CLIENTS'(1) << w_winner;
          w_owner_nxt = w_winner;
          w_data_nxt  = w_delay_arr[w_winner];
          // A zero delay never touches the Timer.
          w_write_nxt = (w_delay_arr[w_winner] != '0);
        end
      end
      S_LOAD: begin
        w_state_nxt = (r_data != '0) ? S_SETTLE : S_DONE;
      end
      S_SETTLE: begin
        // Interrupt may still be high from the previous expiry; skip one cycle.
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (timer_interrupt) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_state_nxt == S_DONE) begin
      w_done_nxt = NUM_CLIENTS'(1) << r_owner;
      w_last_nxt = r_owner;
    end
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_write <= 1'b0;
      r_data  <= '0;
      r_owner <= '0;
      r_last  <= IDX_WIDTH'(NUM_CLIENTS - 1);
    end else begin
      r_ack   <= w_ack_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      r_write <= w_write_nxt;
      r_data  <= w_data_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign ack         = r_ack;
  assign done        = r_done;
  assign busy        = r_busy;
  assign owner       = r_owner;
  assign timer_write = r_write;
  assign timer_data  = r_data;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with a behavioural Timer (8 prescale bits).
module tb_timer_scheduler;
  localparam int unsigned NC       = 4;
  localparam int unsigned DW       = 32;
  localparam int unsigned IW       = 2;
  localparam int unsigned ADD_BITS = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NC-1:0]  req;
  logic [NC*DW-1:0] delay;
  logic [NC-1:0]  ack;
  logic [NC-1:0]  done;
  logic           busy;
  logic [IW-1:0]  owner;
  logic           timer_write;
  logic [DW-1:0]  timer_data;
  logic           timer_interrupt;

  int n_err = 0;
  int n_chk = 0;

  logic [63:0] tm_cnt = '0;
  logic        tm_irq = 1'b0;
  logic        irq_man;

  int            inv_bad  = 0;
  int            done_cnt = 0;
  int            wr_cnt   = 0;
  logic          mon_open = 1'b0;
  logic [NC-1:0] mon_owner = '0;

  always #5 clk = ~clk;

  timer_scheduler #(.NUM_CLIENTS(NC), .DELAY_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .delay           (delay),
    .ack             (ack),
    .done            (done),
    .busy            (busy),
    .owner           (owner),
    .timer_write     (timer_write),
    .timer_data      (timer_data),
    .timer_interrupt (timer_interrupt)
  );

  // Timer model: write loads delay<<ADD_BITS and clears the interrupt; expiry holds it high.
  always @(posedge clk) begin
    if (timer_write) begin
      tm_cnt <= 64'(timer_data) << ADD_BITS;
      tm_irq <= 1'b0;
    end else if (tm_cnt != 0) begin
      tm_cnt <= tm_cnt - 1;
      if (tm_cnt == 1) tm_irq <= 1'b1;
    end
  end
  assign timer_interrupt = tm_irq | irq_man;

  // Protocol monitor: one-hot pulses, no ack/done overlap, no overlapping grants.
  always @(negedge clk) begin
    if (!rst) begin
      mon_open = 1'b0;
    end else begin
      if (!$onehot0(ack) || !$onehot0(done) || ((|ack) && (|done))) inv_bad++;
      if (|ack) begin
        if (mon_open) inv_bad++;
        mon_open  = 1'b1;
        mon_owner = ack;
      end
      if (|done) begin
        if (!mon_open || done != mon_owner) inv_bad++;
        mon_open = 1'b0;
        done_cnt++;
      end
      if (timer_write) wr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_delay(input int c, input logic [DW-1:0] v);
    delay[c*DW +: DW] = v;
  endtask

  task automatic wait_ack(input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == '0 && n < lim);
    check("ack_seen", 64'(|ack), 64'd1);
  endtask

  task automatic wait_done(input int lim, output int n, output logic bok);
    n   = 0;
    bok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (busy !== 1'b1) bok = 1'b0;
    end while (done == '0 && n < lim);
    check("done_seen", 64'(|done), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   64'(ack),         64'd0);
    check({tag, "_done"},  64'(done),        64'd0);
    check({tag, "_busy"},  64'(busy),        64'd0);
    check({tag, "_owner"}, 64'(owner),       64'd0);
    check({tag, "_write"}, 64'(timer_write), 64'd0);
    check({tag, "_data"},  64'(timer_data),  64'd0);
  endtask

  initial begin
    int   n;
    logic bok;
    int   base;

    rst     = 1'b0;
    req     = '0;
    delay   = '0;
    irq_man = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // Contention: all four request, delays 1..4, grant order 0,1,2,3.
    for (int i = 0; i < NC; i++) set_delay(i, DW'(i + 1));
    req = 4'b1111;
    for (int i = 0; i < NC; i++) begin
      wait_ack(10, n);
      if (i == 0) check("cont_ack_latency", 64'(n), 64'd1);
      else        check("cont_gap_after_done", 64'(n), 64'd2);
      check("cont_ack", 64'(ack), 64'(1) << i);
      check("cont_owner", 64'(owner), 64'(i));
      check("cont_write", 64'(timer_write), 64'd1);
      check("cont_data", 64'(timer_data), 64'(i + 1));
      req[i] = 1'b0;
      wait_done(2000, n, bok);
      check("cont_done", 64'(done), 64'(1) << i);
      check("cont_busy_held", 64'(bok), 64'd1);
    end

    // Round-robin: client 2 alone, then 1 and 3 together -> 3 before 1.
    set_delay(2, 1);
    req = 4'b0100;
    wait_ack(10, n);
    check("rr_c2_ack", 64'(ack), 64'd4);
    req = '0;
    wait_done(2000, n, bok);
    check("rr_c2_done", 64'(done), 64'd4);
    set_delay(1, 1);
    set_delay(3, 2);
    req = 4'b1010;
    wait_ack(10, n);
    check("rr_c3_first", 64'(ack), 64'd8);
    check("rr_c3_owner", 64'(owner), 64'd3);
    req[3] = 1'b0;
    wait_done(2000, n, bok);
    check("rr_c3_done", 64'(done), 64'd8);
    wait_ack(10, n);
    check("rr_c1_second", 64'(ack), 64'd2);
    req[1] = 1'b0;
    wait_done(2000, n, bok);
    check("rr_c1_done", 64'(done), 64'd2);

    // Zero delay: Timer bypassed, done the cycle after ack.
    set_delay(1, 0);
    base = wr_cnt;
    req  = 4'b0010;
    wait_ack(10, n);
    check("zero_ack", 64'(ack), 64'd2);
    check("zero_write", 64'(timer_write), 64'd0);
    check("zero_data", 64'(timer_data), 64'd0);
    req = '0;
    @(negedge clk);
    check("zero_done_next", 64'(done), 64'd2);
    check("zero_no_write", 64'(wr_cnt - base), 64'd0);

    // Single client 0, delay 3: expiry 768 cycles plus scheduler overhead.
    @(negedge clk);
    set_delay(0, 3);
    req = 4'b0001;
    wait_ack(10, n);
    check("single_ack_latency", 64'(n), 64'd1);
    check("single_ack", 64'(ack), 64'd1);
    check("single_write", 64'(timer_write), 64'd1);
    check("single_data", 64'(timer_data), 64'd3);
    check("single_busy", 64'(busy), 64'd1);
    req = '0;
    wait_done(2000, n, bok);
    check("single_delay_in_range", 64'(n >= 768 && n <= 772), 64'd1);
    check("single_busy_held", 64'(bok), 64'd1);
    check("single_done", 64'(done), 64'd1);
    @(negedge clk);
    check("single_idle_busy", 64'(busy), 64'd0);
    check("single_done_pulse", 64'(done), 64'd0);

    // Stale interrupt held through LOAD and SETTLE must not complete the grant.
    irq_man = 1'b1;
    set_delay(2, 1);
    req = 4'b0100;
    wait_ack(10, n);
    base = done_cnt;
    check("stale_ack", 64'(ack), 64'd4);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    irq_man = 1'b0;
    repeat (100) @(negedge clk);
    check("stale_no_early_done", 64'(done_cnt - base), 64'd0);
    wait_done(400, n, bok);
    check("stale_done", 64'(done), 64'd4);

    // Reset while waiting: outputs clear immediately, grant aborted, client 0 first after.
    @(negedge clk);
    set_delay(3, 2);
    req = 4'b1000;
    wait_ack(10, n);
    check("rstw_ack", 64'(ack), 64'd8);
    req = '0;
    repeat (50) @(negedge clk);
    check("rstw_busy_in_wait", 64'(busy), 64'd1);
    base = done_cnt;
    #2 rst = 1'b0;
    #1;
    check_all_zero("rstw");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (600) @(negedge clk);
    check("rstw_no_done", 64'(done_cnt - base), 64'd0);
    set_delay(0, 1);
    set_delay(3, 1);
    req = 4'b1001;
    wait_ack(10, n);
    check("rstw_c0_first", 64'(ack), 64'd1);
    req[0] = 1'b0;
    wait_done(2000, n, bok);
    check("rstw_c0_done", 64'(done), 64'd1);
    wait_ack(10, n);
    check("rstw_c3_second", 64'(ack), 64'd8);
    check("rstw_c3_owner", 64'(owner), 64'd3);
    req = '0;
    wait_done(2000, n, bok);
    check("rstw_c3_done", 64'(done), 64'd8);
    @(negedge clk);

    check("protocol_invariants", 64'(inv_bad), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
